// File: rtl/sign_job_loader_if.sv
// Host-to-signer bundle for sign_job_loader: word stream in, three-operand job out.
// master = host/signer side, slave = the loader.
interface sign_job_loader_if #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              flush;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DATA_W-1:0] job_hash;
  logic [DATA_W-1:0] job_key;
  logic [DATA_W-1:0] job_nonce;
  logic              job_valid;
  logic              job_ready;
  logic              job_err;

  modport master (
    output data_in, data_valid, flush, job_ready,
    input  data_ready, level, overflow, job_hash, job_key, job_nonce, job_valid, job_err
  );

  modport slave (
    input  data_in, data_valid, flush, job_ready,
    output data_ready, level, overflow, job_hash, job_key, job_nonce, job_valid, job_err
  );
endinterface

// File: rtl/sign_job_loader.sv
// FIFO-fed assembler packing hash/key/nonce word triples into signer jobs.
// SIGN_JOB_LOADER_RANGE_CHECK_EN: drop jobs whose key or nonce is zero (pulses job_err).
//   state   | meaning
//   COLLECT | pop FIFO words into slot idx (hash, key, nonce)
//   CHECK   | one-cycle validation, then present or drop
//   PRESENT | job_valid high, operands frozen until job_ready
module sign_job_loader #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  sign_job_loader_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {COLLECT, CHECK, PRESENT} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              overflow_q;
  state_t            state_q;
  logic [1:0]        idx_q;
  logic [DATA_W-1:0] hash_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] nonce_q;
  logic              job_valid_q;
  logic              data_ready;
  logic              push;
  logic              pop;

  assign data_ready = (level_q != LVL_FULL);
  assign push = bus.data_valid && data_ready && !bus.flush;
  assign pop  = (state_q == COLLECT) && (level_q != '0) && !bus.flush;

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  // Storage is deliberately left unreset; level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (bus.data_valid && !data_ready)
        overflow_q <= 1'b1;
    end
  end

`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
  logic job_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= 2'd0;
      hash_q      <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      job_valid_q <= 1'b0;
`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
      job_err_q   <= 1'b0;
`endif
    end else begin
`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
      job_err_q <= 1'b0;
`endif
      if (bus.flush) begin
        state_q     <= COLLECT;
        idx_q       <= 2'd0;
        job_valid_q <= 1'b0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (pop) begin
              case (idx_q)
                2'd0:    hash_q  <= mem_q[rd_ptr_q];
                2'd1:    key_q   <= mem_q[rd_ptr_q];
                default: nonce_q <= mem_q[rd_ptr_q];
              endcase
              if (idx_q == 2'd2) begin
                idx_q   <= 2'd0;
                state_q <= CHECK;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
          CHECK: begin
`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
            if (key_q == '0 || nonce_q == '0) begin
              job_err_q <= 1'b1;
              state_q   <= COLLECT;
            end else begin
              job_valid_q <= 1'b1;
              state_q     <= PRESENT;
            end
`else
            job_valid_q <= 1'b1;
            state_q     <= PRESENT;
`endif
          end
          PRESENT: begin
            if (bus.job_ready) begin
              job_valid_q <= 1'b0;
              state_q     <= COLLECT;
            end
          end
          default: begin
            job_valid_q <= 1'b0;
            idx_q       <= 2'd0;
            state_q     <= COLLECT;
          end
        endcase
      end
    end
  end

  assign bus.data_ready = data_ready;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.job_hash   = hash_q;
  assign bus.job_key    = key_q;
  assign bus.job_nonce  = nonce_q;
  assign bus.job_valid  = job_valid_q;
`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
  assign bus.job_err    = job_err_q;
`else
  assign bus.job_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sign_job_loader.sv
// Directed bench for sign_job_loader (DEPTH = 4); honours SIGN_JOB_LOADER_RANGE_CHECK_EN.
module tb_sign_job_loader;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sign_job_loader_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sign_job_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives three words on consecutive cycles; returns in the cycle after the third push.
  task automatic push_job(input logic [DATA_W-1:0] h, input logic [DATA_W-1:0] k,
                          input logic [DATA_W-1:0] n);
    bus.data_valid = 1'b1;
    bus.data_in = h;
    step();
    bus.data_in = k;
    step();
    bus.data_in = n;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready got=%b exp=1", bus.data_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.job_valid !== 1'b0 || bus.job_err !== 1'b0) begin errors++; $display("FAIL reset_job_flags got=%b%b exp=00", bus.job_valid, bus.job_err); end
    checks++; if (bus.job_hash !== '0 || bus.job_key !== '0 || bus.job_nonce !== '0) begin errors++; $display("FAIL reset_operands got=%h/%h/%h exp=0", bus.job_hash, bus.job_key, bus.job_nonce); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_job();
    bus.job_ready = 1'b1;
    push_job({32{8'hA5}}, 256'h1, 256'h2);
    step();
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", bus.job_valid); end
    step();
    checks++; if (bus.job_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_t5 got=%b exp=1", bus.job_valid); end
    checks++; if (bus.job_hash !== {32{8'hA5}}) begin errors++; $display("FAIL basic_hash got=%h exp=%h", bus.job_hash, {32{8'hA5}}); end
    checks++; if (bus.job_key !== 256'h1 || bus.job_nonce !== 256'h2) begin errors++; $display("FAIL basic_key_nonce got=%h/%h exp=1/2", bus.job_key, bus.job_nonce); end
    step();
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake got=%b exp=0", bus.job_valid); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL basic_level got=%0d exp=0", bus.level); end
  endtask

  task automatic test_overflow_flush();
    bus.job_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in = DATA_W'(32'h50 + i);
      step();
    end
    bus.data_valid = 1'b0;
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL ovf_level_full got=%0d exp=4", bus.level); end
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL ovf_data_ready got=%b exp=0", bus.data_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_word7_accepted got=%b exp=0", bus.overflow); end
    checks++; if (bus.job_valid !== 1'b1 || bus.job_hash !== 256'h50) begin errors++; $display("FAIL ovf_job_held got=%b/%h exp=1/50", bus.job_valid, bus.job_hash); end
    bus.data_valid = 1'b1;
    bus.data_in = 256'hDEAD;
    step();
    bus.data_valid = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL ovf_level_unchanged got=%0d exp=4", bus.level); end
    step();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", bus.overflow); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.level !== 3'd0 || bus.data_ready !== 1'b1) begin errors++; $display("FAIL flush_level got=%0d/%b exp=0/1", bus.level, bus.data_ready); end
    checks++; if (bus.overflow !== 1'b0 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL flush_flags got=%b/%b exp=0/0", bus.overflow, bus.job_valid); end
  endtask

  task automatic test_wrap_stream();
    logic [DATA_W-1:0] words [9];
    logic [DATA_W-1:0] got_h [3];
    logic [DATA_W-1:0] got_k [3];
    logic [DATA_W-1:0] got_n [3];
    int n;
    int jobs;
    int cyc;
    for (int i = 0; i < 9; i++) words[i] = DATA_W'(32'h1000 + i);
    n = 0;
    jobs = 0;
    cyc = 0;
    bus.job_ready = 1'b1;
    while (jobs < 3 && cyc < 200) begin
      if (bus.job_valid === 1'b1) begin
        got_h[jobs] = bus.job_hash;
        got_k[jobs] = bus.job_key;
        got_n[jobs] = bus.job_nonce;
        jobs++;
      end
      if (n < 9 && bus.data_ready === 1'b1) begin
        bus.data_valid = 1'b1;
        bus.data_in = words[n];
        n++;
      end else begin
        bus.data_valid = 1'b0;
      end
      step();
      cyc++;
    end
    bus.data_valid = 1'b0;
    checks++; if (jobs != 3) begin errors++; $display("FAIL wrap_job_count got=%0d exp=3", jobs); end
    for (int j = 0; j < jobs; j++) begin
      checks++;
      if (got_h[j] !== words[3*j] || got_k[j] !== words[3*j+1] || got_n[j] !== words[3*j+2]) begin
        errors++;
        $display("FAIL wrap_job%0d got=%h/%h/%h exp=%h/%h/%h", j, got_h[j][15:0], got_k[j][15:0], got_n[j][15:0],
                 words[3*j][15:0], words[3*j+1][15:0], words[3*j+2][15:0]);
      end
    end
    step();
    checks++; if (bus.level !== 3'd0 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%0d/%b exp=0/0", bus.level, bus.job_valid); end
  endtask

  task automatic test_range_check();
    bus.job_ready = 1'b1;
    push_job(256'hABC, 256'h0, 256'h5);
    step();
    step();
`ifdef SIGN_JOB_LOADER_RANGE_CHECK_EN
    checks++; if (bus.job_err !== 1'b1 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL range_drop got=err%b/valid%b exp=err1/valid0", bus.job_err, bus.job_valid); end
    step();
    checks++; if (bus.job_err !== 1'b0 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL range_pulse_width got=err%b/valid%b exp=err0/valid0", bus.job_err, bus.job_valid); end
`else
    checks++; if (bus.job_valid !== 1'b1 || bus.job_key !== '0 || bus.job_err !== 1'b0) begin errors++; $display("FAIL range_pass got=valid%b/key%h/err%b exp=1/0/0", bus.job_valid, bus.job_key, bus.job_err); end
    step();
`endif
    push_job(256'h1, 256'h2, 256'h3);
    step();
    step();
    checks++;
    if (bus.job_valid !== 1'b1 || bus.job_hash !== 256'h1 || bus.job_key !== 256'h2 || bus.job_nonce !== 256'h3) begin
      errors++;
      $display("FAIL range_next_job got=%b/%h/%h/%h exp=1/1/2/3", bus.job_valid, bus.job_hash[15:0], bus.job_key[15:0], bus.job_nonce[15:0]);
    end
    step();
  endtask

  task automatic test_reset_mid_job();
    bus.job_ready = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in = 256'h11;
    step();
    bus.data_in = 256'h22;
    step();
    bus.data_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.level !== 3'd0 || bus.data_ready !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_fifo got=%0d/%b/%b exp=0/1/0", bus.level, bus.data_ready, bus.overflow); end
    checks++; if (bus.job_hash !== '0 || bus.job_key !== '0 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL midrst_job got=%h/%h/%b exp=0/0/0", bus.job_hash[15:0], bus.job_key[15:0], bus.job_valid); end
    rst = 1'b0;
    step();
    push_job(256'h31, 256'h32, 256'h33);
    step();
    step();
    checks++;
    if (bus.job_valid !== 1'b1 || bus.job_hash !== 256'h31 || bus.job_key !== 256'h32 || bus.job_nonce !== 256'h33) begin
      errors++;
      $display("FAIL midrst_new_job got=%b/%h/%h/%h exp=1/31/32/33", bus.job_valid, bus.job_hash[15:0], bus.job_key[15:0], bus.job_nonce[15:0]);
    end
    step();
  endtask

  task automatic test_push_with_flush();
    bus.job_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in = DATA_W'(32'h70 + i);
      step();
    end
    bus.data_valid = 1'b0;
    checks++; if (bus.level !== 3'd2 || bus.job_valid !== 1'b1) begin errors++; $display("FAIL pf_setup got=%0d/%b exp=2/1", bus.level, bus.job_valid); end
    bus.data_valid = 1'b1;
    bus.data_in = 256'hF0;
    bus.flush = 1'b1;
    step();
    bus.data_valid = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL pf_level got=%0d exp=0", bus.level); end
    checks++; if (bus.overflow !== 1'b0 || bus.job_valid !== 1'b0) begin errors++; $display("FAIL pf_flags got=%b/%b exp=0/0", bus.overflow, bus.job_valid); end
    step();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL pf_no_pending_push got=%0d exp=0", bus.level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.flush = 1'b0;
    bus.job_ready = 1'b0;
    test_reset();
    test_basic_job();
    test_overflow_flush();
    test_wrap_stream();
    test_range_check();
    test_reset_mid_job();
    test_push_with_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sign_job_loader.md
# sign_job_loader

Parametrised successor to the single-word memory loader. It buffers a stream of DATA_W-bit words in a DEPTH-entry FIFO and assembles every three consecutive words into one signing job: hash, then private key, then nonce. Each job is presented to the ECDSA signer as three parallel operands under a valid/ready handshake. The block sits between the host-side data path and the signer's `msg_in`/`priv_key`/`nonce` inputs.

## Interface
- `DATA_W`, 256, operand width in bits; every FIFO word and every job operand is this width.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 4.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_in`  in  DATA_W  word to enqueue.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  FIFO can accept a word; equals `level != DEPTH`.
- `flush`  in  1  synchronous clear of FIFO, assembler and sticky flags.
- `level`  out  $clog2(DEPTH+1)  number of words currently held in the FIFO.
- `overflow`  out  1  sticky; set when `data_valid` is high while `data_ready` is low.
- `job_hash`, `job_key`, `job_nonce`  out  DATA_W each  operands of the assembled job.
- `job_valid`  out  1  job operands are valid.
- `job_ready`  in  1  signer accepts the job.
- `job_err`  out  1  one-cycle pulse when an assembled job is dropped (see Configuration).

## Operation
- Push: when `data_valid && data_ready`, write `data_in` at the write pointer. The write pointer advances modulo DEPTH.
- Rejected push: when `data_valid && !data_ready`, discard the word and set `overflow`. FIFO contents are unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. `level` is a separate counter: +1 on push only, −1 on pop only, unchanged when both occur in the same cycle.
- A push and a pop in the same cycle are both performed when level is between 1 and DEPTH−1.
- When the FIFO is full, `data_ready` is 0, so no push occurs even if a pop happens that cycle.
- Assembler FSM states:
  - `COLLECT`: holds slot index `idx` (0..2). Each cycle the FIFO is non-empty, pop the head word into slot `idx` (0 = hash, 1 = key, 2 = nonce). When `idx` = 2, the pop moves the FSM to `CHECK` and resets `idx` to 0; otherwise `idx` increments.
  - `CHECK`: one cycle. Go to `PRESENT`, or drop the job: pulse `job_err` and return to `COLLECT`.
  - `PRESENT`: `job_valid` = 1. Operands are held stable and no popping occurs. On `job_valid && job_ready`, return to `COLLECT`. The next pop may happen in that same handshake cycle's successor.
- `flush` has priority over push, pop and handshake in the same cycle. It clears the pointers, `level`, `overflow`, `idx` and `job_valid`, and puts the FSM in `COLLECT`. FIFO storage and operand registers are not cleared.
- Assertion of `rst` at any time, including mid-job, immediately returns all state to reset values. A partially collected job is lost.

## Timing
- Reset values:
  - `level` = 0, `data_ready` = 1, `overflow` = 0.
  - `job_valid` = 0, `job_err` = 0.
  - `job_hash`, `job_key`, `job_nonce` = 0.
  - FSM = `COLLECT`, `idx` = 0.
- A word pushed in cycle t can be popped no earlier than cycle t+1.
- With pushes at t, t+1, t+2 into an empty FIFO and the FSM idle:
  - pops occur at t+1, t+2, t+3;
  - `CHECK` is at t+4;
  - `job_valid` rises at t+5 (or `job_err` pulses at t+5).
- `CHECK` is always present, so latency is identical with and without the Configuration macro.
- Throughput is one job per 5 cycles when `job_ready` is tied high and the FIFO is never starved.
- `data_ready`, `level` and `overflow` reflect registered state; none depends combinationally on `data_valid`.

## Configuration
- Macro: `SIGN_JOB_LOADER_RANGE_CHECK_EN`.
- Defined: in `CHECK`, a job with `job_key` == 0 or `job_nonce` == 0 is dropped. `job_err` pulses for one cycle, `job_valid` stays 0, and the FSM returns to `COLLECT`.
- Undefined: `CHECK` always proceeds to `PRESENT`, and `job_err` is tied to 0.

## Test plan
- Reset, then push A5..A5, 0x1, 0x2 on consecutive cycles with `job_ready` = 1 → `job_valid` at push0+5 with hash = A5..A5, key = 1, nonce = 2. Handshake completes in one cycle, and `level` returns to 0.
- DATA_W = 256, DEPTH = 4, `job_ready` = 0: push 7 words → words 1–6 accepted and first job held in `PRESENT`. Word 7 is accepted only if `level` < 4; otherwise it is rejected, `overflow` = 1 and `data_ready` = 0. Then assert `flush` → `level` = 0, `overflow` = 0, `job_valid` = 0.
- Push 9 words with DEPTH = 4 while `job_ready` = 1 and pushes are paced on `data_ready` → 3 jobs emitted in order; pointer wrap occurs without corruption.
- Macro defined: push hash = 0xABC, key = 0, nonce = 5 → `job_err` pulses at push0+5 and no `job_valid`. The next job (0x1, 0x2, 0x3) is presented normally. Macro undefined: the same stimulus → `job_valid` with key = 0.
- Assert `rst` for one cycle after 2 of 3 words have been popped → all outputs at reset values. Then push 3 new words → a job is formed only from the new words.
- Push and `flush` in the same cycle with `level` = 2 → push ignored, `level` = 0 next cycle, and `overflow` unchanged at 0.
